// File: rtl/filt_frame_sched.sv
// Filter-frame sequencer for a PE row: replays the taps of one latched frame
// NUM_SENDS times with programmable idle gaps, then forwards the frame unchanged.
// Optional counters (frames_done, stall_cycles) are built when FILT_SCHED_STATS_EN is defined.
module filt_frame_sched #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned NTAPS     = 3,
  parameter int unsigned NUM_SENDS = 3,
  parameter int unsigned GAP_PRE   = 2,
  parameter int unsigned GAP_POST  = 2,
  localparam int unsigned IDX_W    = (NTAPS > 1) ? $clog2(NTAPS) : 1,
  localparam int unsigned FW       = DWIDTH * NTAPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_in_valid,
  output logic              frame_in_ready,
  input  logic [FW-1:0]     frame_in_data,
  output logic              tap_out_valid,
  input  logic              tap_out_ready,
  output logic [DWIDTH-1:0] tap_out_data,
  output logic [IDX_W-1:0]  tap_out_idx,
  output logic              tap_out_last,
  output logic              frame_out_valid,
  input  logic              frame_out_ready,
  output logic [FW-1:0]     frame_out_data,
  output logic              busy
`ifdef FILT_SCHED_STATS_EN
  ,
  output logic [15:0]       frames_done,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int unsigned PASS_W  = (NUM_SENDS > 1) ? $clog2(NUM_SENDS) : 1;
  localparam int unsigned GAP_MAX = (GAP_PRE > GAP_POST) ? GAP_PRE : GAP_POST;
  localparam int unsigned CNT_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NTAPS - 1);
  localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_SENDS - 1);
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'((GAP_PRE > 0) ? GAP_PRE - 1 : 0);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'((GAP_POST > 0) ? GAP_POST - 1 : 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_TAP  = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_FWD  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [FW-1:0]     frame_q, frame_d;

  logic              in_ready_q, in_ready_d;
  logic              tap_valid_q, tap_valid_d;
  logic [DWIDTH-1:0] tap_data_q, tap_data_d;
  logic [IDX_W-1:0]  tap_idx_q, tap_idx_d;
  logic              tap_last_q, tap_last_d;
  logic              fout_valid_q, fout_valid_d;
  logic [FW-1:0]     fout_data_q, fout_data_d;
  logic              busy_q, busy_d;

  // Step taken after a tap's post-gap: next tap, next pass, or forward.
  logic [2:0]        adv_state;
  logic [IDX_W-1:0]  adv_idx;
  logic [PASS_W-1:0] adv_pass;

  always_comb begin
    adv_idx   = idx_q - IDX_W'(1);
    adv_pass  = pass_q;
    adv_state = (GAP_PRE == 0) ? S_TAP : S_PRE;
    if (idx_q == '0) begin
      adv_idx = IDX_LAST;
      if (pass_q == PASS_LAST) begin
        adv_state = S_FWD;
      end else begin
        adv_pass = pass_q + PASS_W'(1);
      end
    end
  end

  // Next-state logic; the output registers are loaded from the next-state values
  // so every port reflects the current state without a combinational path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    frame_d = frame_q;

    case (state_q)
      S_IDLE: begin
        if (frame_in_valid && in_ready_q) begin
          frame_d = frame_in_data;
          idx_d   = IDX_LAST;
          pass_d  = '0;
          cnt_d   = '0;
          state_d = (GAP_PRE == 0) ? S_TAP : S_PRE;
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = S_TAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TAP: begin
        if (tap_valid_q && tap_out_ready) begin
          cnt_d = '0;
          if (GAP_POST == 0) begin
            state_d = adv_state;
            idx_d   = adv_idx;
            pass_d  = adv_pass;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (cnt_q == POST_LAST) begin
          cnt_d   = '0;
          state_d = adv_state;
          idx_d   = adv_idx;
          pass_d  = adv_pass;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FWD: begin
        if (fout_valid_q && frame_out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d   = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    tap_valid_d  = (state_d == S_TAP);
    tap_data_d   = '0;
    tap_idx_d    = '0;
    tap_last_d   = 1'b0;
    fout_valid_d = (state_d == S_FWD);
    fout_data_d  = '0;
    if (state_d == S_TAP) begin
      tap_data_d = frame_d[DWIDTH*int'(idx_d) +: DWIDTH];
      tap_idx_d  = idx_d;
      tap_last_d = (idx_d == '0) && (pass_d == PASS_LAST);
    end
    if (state_d == S_FWD) begin
      fout_data_d = frame_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      pass_q       <= '0;
      frame_q      <= '0;
      in_ready_q   <= 1'b0;
      tap_valid_q  <= 1'b0;
      tap_data_q   <= '0;
      tap_idx_q    <= '0;
      tap_last_q   <= 1'b0;
      fout_valid_q <= 1'b0;
      fout_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pass_q       <= pass_d;
      frame_q      <= frame_d;
      in_ready_q   <= in_ready_d;
      tap_valid_q  <= tap_valid_d;
      tap_data_q   <= tap_data_d;
      tap_idx_q    <= tap_idx_d;
      tap_last_q   <= tap_last_d;
      fout_valid_q <= fout_valid_d;
      fout_data_q  <= fout_data_d;
      busy_q       <= busy_d;
    end
  end

  assign frame_in_ready  = in_ready_q;
  assign tap_out_valid   = tap_valid_q;
  assign tap_out_data    = tap_data_q;
  assign tap_out_idx     = tap_idx_q;
  assign tap_out_last    = tap_last_q;
  assign frame_out_valid = fout_valid_q;
  assign frame_out_data  = fout_data_q;
  assign busy            = busy_q;

`ifdef FILT_SCHED_STATS_EN
  // Frame count wraps; stall count saturates so long stalls stay visible.
  logic [15:0] frames_done_q;
  logic [15:0] stall_q;
  logic        stalled;

  assign stalled = (tap_valid_q && !tap_out_ready) || (fout_valid_q && !frame_out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_done_q <= '0;
      stall_q       <= '0;
    end else begin
      if (fout_valid_q && frame_out_ready) begin
        frames_done_q <= frames_done_q + 16'd1;
      end
      if (stalled && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign frames_done  = frames_done_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_filt_frame_sched.sv
// Directed bench for filt_frame_sched: default-parameter instance plus a
// zero-gap single-pass instance; counter checks when FILT_SCHED_STATS_EN is set.
module tb_filt_frame_sched;

  logic        clk;
  logic        rst_n;

  logic        frame_in_valid, frame_in_ready;
  logic [23:0] frame_in_data;
  logic        tap_out_valid, tap_out_ready;
  logic [7:0]  tap_out_data;
  logic [1:0]  tap_out_idx;
  logic        tap_out_last;
  logic        frame_out_valid, frame_out_ready;
  logic [23:0] frame_out_data;
  logic        busy;

  logic        d0_frame_in_valid, d0_frame_in_ready;
  logic [23:0] d0_frame_in_data;
  logic        d0_tap_out_valid, d0_tap_out_ready;
  logic [7:0]  d0_tap_out_data;
  logic [1:0]  d0_tap_out_idx;
  logic        d0_tap_out_last;
  logic        d0_frame_out_valid, d0_frame_out_ready;
  logic [23:0] d0_frame_out_data;
  logic        d0_busy;

`ifdef FILT_SCHED_STATS_EN
  logic [15:0] frames_done, stall_cycles;
  logic [15:0] d0_frames_done, d0_stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  filt_frame_sched dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_in_valid  (frame_in_valid),
    .frame_in_ready  (frame_in_ready),
    .frame_in_data   (frame_in_data),
    .tap_out_valid   (tap_out_valid),
    .tap_out_ready   (tap_out_ready),
    .tap_out_data    (tap_out_data),
    .tap_out_idx     (tap_out_idx),
    .tap_out_last    (tap_out_last),
    .frame_out_valid (frame_out_valid),
    .frame_out_ready (frame_out_ready),
    .frame_out_data  (frame_out_data),
    .busy            (busy)
`ifdef FILT_SCHED_STATS_EN
    ,
    .frames_done     (frames_done),
    .stall_cycles    (stall_cycles)
`endif
  );

  filt_frame_sched #(
    .NUM_SENDS (1),
    .GAP_PRE   (0),
    .GAP_POST  (0)
  ) dut0 (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_in_valid  (d0_frame_in_valid),
    .frame_in_ready  (d0_frame_in_ready),
    .frame_in_data   (d0_frame_in_data),
    .tap_out_valid   (d0_tap_out_valid),
    .tap_out_ready   (d0_tap_out_ready),
    .tap_out_data    (d0_tap_out_data),
    .tap_out_idx     (d0_tap_out_idx),
    .tap_out_last    (d0_tap_out_last),
    .frame_out_valid (d0_frame_out_valid),
    .frame_out_ready (d0_frame_out_ready),
    .frame_out_data  (d0_frame_out_data),
    .busy            (d0_busy)
`ifdef FILT_SCHED_STATS_EN
    ,
    .frames_done     (d0_frames_done),
    .stall_cycles    (d0_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Tap number i (0-based) of a frame is tap index 2 - i%3.
  function automatic logic [7:0] tap_of(input logic [23:0] f, input int i);
    int k;
    k = 2 - (i % 3);
    return f[8*k +: 8];
  endfunction

  // Runs one frame on the default instance. Cycle n is the negedge just before
  // the n-th rising edge after the accept edge. Optional disturbances:
  // stall_tap/stall_len hold tap_out_ready low, pulse_tap offers a second frame,
  // rst_tap pulses reset while that tap is offered, fwd_stall holds frame_out_ready low.
  task automatic run_frame(input logic [23:0] frm, input int stall_tap, input int stall_len,
                           input int pulse_tap, input int rst_tap, input int fwd_stall);
    int          cyc, tap_n, stalled, fwd_wait, last_cnt, frame_cyc, exp_cyc;
    int          hs_cyc[16];
    logic [7:0]  hs_data[16];
    logic [1:0]  hs_idx[16];
    logic        hs_last[16];
    logic [23:0] frame_got;
    logic        done, pulsed;
    cyc = 0; tap_n = 0; stalled = 0; fwd_wait = 0; last_cnt = 0; frame_cyc = 0;
    frame_got = '0; done = 1'b0; pulsed = 1'b0;
    @(negedge clk);
    check("in_ready_idle", 32'(frame_in_ready), 32'd1);
    frame_in_valid = 1'b1;
    frame_in_data  = frm;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      frame_in_valid  = 1'b0;
      tap_out_ready   = 1'b1;
      frame_out_ready = 1'b1;
      if (cyc == 1) begin
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_after_accept", 32'(frame_in_ready), 32'd0);
      end
      if (tap_out_valid && rst_tap == tap_n + 1) begin
        rst_n = 1'b0;
        #1;
        check("rst_tap_valid", 32'(tap_out_valid), 32'd0);
        check("rst_frame_valid", 32'(frame_out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_in_ready", 32'(frame_in_ready), 32'd1);
        check("post_rst_tap_valid", 32'(tap_out_valid), 32'd0);
        return;
      end
      if (pulse_tap == tap_n && !pulsed) begin
        pulsed = 1'b1;
        frame_in_valid = 1'b1;
        frame_in_data  = 24'h112233;
        check("in_ready_while_busy", 32'(frame_in_ready), 32'd0);
      end
      if (tap_out_valid && stall_tap == tap_n + 1 && stalled < stall_len) begin
        tap_out_ready = 1'b0;
        stalled++;
        check("stall_data", 32'(tap_out_data), 32'(tap_of(frm, tap_n)));
        check("stall_idx", 32'(tap_out_idx), 32'(2 - (tap_n % 3)));
      end
      if (tap_out_last) last_cnt++;
      if (tap_out_valid && tap_out_ready) begin
        if (tap_n < 16) begin
          hs_cyc[tap_n]  = cyc;
          hs_data[tap_n] = tap_out_data;
          hs_idx[tap_n]  = tap_out_idx;
          hs_last[tap_n] = tap_out_last;
        end
        tap_n++;
      end
      if (frame_out_valid) begin
        if (fwd_wait < fwd_stall) begin
          frame_out_ready = 1'b0;
          fwd_wait++;
        end else begin
          frame_cyc = cyc;
          frame_got = frame_out_data;
          done      = 1'b1;
        end
      end
    end
    frame_in_valid = 1'b0;
    check("frame_done_in_time", 32'(done), 32'd1);
    check("tap_count", 32'(tap_n), 32'd9);
    if (stall_len > 0) check("stall_cycles_seen", 32'(stalled), 32'(stall_len));
    for (int i = 0; i < 9 && i < tap_n; i++) begin
      exp_cyc = 3 + 5 * i + ((stall_tap > 0 && i + 1 >= stall_tap) ? stall_len : 0);
      check($sformatf("tap%0d_cycle", i), 32'(hs_cyc[i]), 32'(exp_cyc));
      check($sformatf("tap%0d_data", i), 32'(hs_data[i]), 32'(tap_of(frm, i)));
      check($sformatf("tap%0d_idx", i), 32'(hs_idx[i]), 32'(2 - (i % 3)));
      check($sformatf("tap%0d_last", i), 32'(hs_last[i]), 32'(i == 8));
    end
    check("last_high_cycles", 32'(last_cnt), 32'd1);
    exp_cyc = 3 + 5 * 8 + ((stall_tap > 0) ? stall_len : 0) + 3 + fwd_stall;
    check("frame_out_cycle", 32'(frame_cyc), 32'(exp_cyc));
    check("frame_out_data", 32'(frame_got), 32'(frm));
    @(negedge clk);
    check("in_ready_after_fwd", 32'(frame_in_ready), 32'd1);
    check("busy_after_fwd", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    frame_in_valid = 1'b0; frame_in_data = '0;
    tap_out_ready = 1'b1; frame_out_ready = 1'b1;
    d0_frame_in_valid = 1'b0; d0_frame_in_data = '0;
    d0_tap_out_ready = 1'b1; d0_frame_out_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(frame_in_ready), 32'd0);
    check("rst_tap_valid0", 32'(tap_out_valid), 32'd0);
    check("rst_frame_valid0", 32'(frame_out_valid), 32'd0);
    check("rst_busy0", 32'(busy), 32'd0);
    check("rst_d0_in_ready", 32'(d0_frame_in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", 32'(frame_in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_first_edge", 32'(frame_in_ready), 32'd1);
    check("d0_in_ready_first_edge", 32'(d0_frame_in_ready), 32'd1);

    // Nominal frame, readies high
    run_frame(24'hA1B2C3, 0, 0, -1, 0, 0);
    // 4th tap held off for 7 cycles
    run_frame(24'hA1B2C3, 4, 7, -1, 0, 0);
    // Second frame offered during pass 2 must be ignored
    run_frame(24'hA1B2C3, 0, 0, 4, 0, 0);
    // Reset during the 5th tap, then a fresh frame from the top
    run_frame(24'hA1B2C3, 0, 0, -1, 5, 0);
    run_frame(24'h0F0E0D, 0, 0, -1, 0, 0);

    // Zero-gap, single-pass instance
    @(negedge clk);
    d0_frame_in_valid = 1'b1;
    d0_frame_in_data  = 24'hA1B2C3;
    @(negedge clk);
    d0_frame_in_valid = 1'b0;
    check("d0_t0_valid", 32'(d0_tap_out_valid), 32'd1);
    check("d0_t0_data", 32'(d0_tap_out_data), 32'hA1);
    check("d0_t0_idx", 32'(d0_tap_out_idx), 32'd2);
    check("d0_t0_last", 32'(d0_tap_out_last), 32'd0);
    @(negedge clk);
    check("d0_t1_valid", 32'(d0_tap_out_valid), 32'd1);
    check("d0_t1_data", 32'(d0_tap_out_data), 32'hB2);
    check("d0_t1_idx", 32'(d0_tap_out_idx), 32'd1);
    check("d0_t1_last", 32'(d0_tap_out_last), 32'd0);
    @(negedge clk);
    check("d0_t2_valid", 32'(d0_tap_out_valid), 32'd1);
    check("d0_t2_data", 32'(d0_tap_out_data), 32'hC3);
    check("d0_t2_idx", 32'(d0_tap_out_idx), 32'd0);
    check("d0_t2_last", 32'(d0_tap_out_last), 32'd1);
    @(negedge clk);
    check("d0_tap_valid_done", 32'(d0_tap_out_valid), 32'd0);
    check("d0_fwd_valid", 32'(d0_frame_out_valid), 32'd1);
    check("d0_fwd_data", 32'(d0_frame_out_data), 32'hA1B2C3);
    @(negedge clk);
    check("d0_fwd_valid_done", 32'(d0_frame_out_valid), 32'd0);
    check("d0_in_ready_after", 32'(d0_frame_in_ready), 32'd1);

`ifdef FILT_SCHED_STATS_EN
    // Counters from a clean reset: three frames, each forward stalled 4 cycles
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("stats_rst_done", 32'(frames_done), 32'd0);
    check("stats_rst_stall", 32'(stall_cycles), 32'd0);
    run_frame(24'hA1B2C3, 0, 0, -1, 0, 4);
    run_frame(24'h0F0E0D, 0, 0, -1, 0, 4);
    run_frame(24'h5A6B7C, 0, 0, -1, 0, 4);
    check("stats_frames_done", 32'(frames_done), 32'd3);
    check("stats_stall_cycles", 32'(stall_cycles), 32'd12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
